// File: rtl/vec_dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vec_dcache_port_arbiter
// Purpose  : Shares one write-through dcache request port between the scalar
//            LSU and the vector unit. Scalar has priority, and the vector unit
//            is forced through after STARVE_LIMIT consecutive losses. The
//            number of granted-but-unanswered transactions is bounded, and
//            scalar loads are held while vector stores are still unacknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module vec_dcache_port_arbiter #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 7,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // scalar requester
  input  logic                s_req_i,
  input  logic                s_we_i,
  input  logic [ADDR_W-1:0]   s_addr_i,
  input  logic [DATA_W-1:0]   s_wdata_i,
  input  logic [DATA_W/8-1:0] s_be_i,
  output logic                s_gnt_o,
  // vector requester
  input  logic                v_req_i,
  input  logic                v_we_i,
  input  logic [ADDR_W-1:0]   v_addr_i,
  input  logic [DATA_W-1:0]   v_wdata_i,
  input  logic [DATA_W/8-1:0] v_be_i,
  output logic                v_gnt_o,
  // dcache request port
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic                m_id_o,
  input  logic                m_gnt_i,
  // dcache response port
  input  logic                m_rvalid_i,
  input  logic                m_rid_i,
  input  logic                m_rwe_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  // responses towards the requesters
  output logic                s_rvalid_o,
  output logic                v_rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                vst_pending_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_LOCK_S = 2'd1;
  localparam logic [1:0] c_ST_LOCK_V = 2'd2;

  localparam logic [CNT_W-1:0] c_MAX_OUT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [STV_W-1:0] c_STV_MAX = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] c_STV_ONE = STV_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [CNT_W-1:0] r_vst_cnt;
  logic [STV_W-1:0] r_starve_cnt;

  logic w_vst_busy;
  logic w_s_elig;
  logic w_v_elig;
  logic w_sel_v;
  logic w_sel_valid;
  logic w_full;
  logic w_req;
  logic w_grant;
  logic w_s_grant;
  logic w_v_grant;
  logic w_vst_inc;
  logic w_vst_dec;
  logic w_out_dec;

  // A scalar load may not overtake a vector store that is still in flight;
  // scalar stores are unaffected.
  assign w_vst_busy = (r_vst_cnt != '0);
  assign w_s_elig   = s_req_i & ~(~s_we_i & w_vst_busy);
  assign w_v_elig   = v_req_i;
  assign w_full     = (r_out_cnt >= c_MAX_OUT);

  // State register: lock state remembers which source was presented but not yet accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: lock on an unaccepted request, release on acceptance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_req && !m_gnt_i) begin
          w_state_nxt = w_sel_v ? c_ST_LOCK_V : c_ST_LOCK_S;
        end
      end
      c_ST_LOCK_S, c_ST_LOCK_V: begin
        if (w_grant) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: source selection, request gating and payload mux.
  always_comb begin
    w_sel_v     = 1'b0;
    w_sel_valid = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_sel_valid = w_s_elig | w_v_elig;
        if (w_s_elig && w_v_elig) begin
          w_sel_v = (r_starve_cnt == c_STV_MAX);
        end else begin
          w_sel_v = w_v_elig;
        end
      end
      c_ST_LOCK_S: begin
        w_sel_v     = 1'b0;
        w_sel_valid = s_req_i;
      end
      c_ST_LOCK_V: begin
        w_sel_v     = 1'b1;
        w_sel_valid = v_req_i;
      end
      default: begin
        w_sel_v     = 1'b0;
        w_sel_valid = 1'b0;
      end
    endcase

    // rst_ni gating keeps every output low while the block is held in reset,
    // even though the request path is purely combinational.
    w_req     = rst_ni & w_sel_valid & ~w_full;
    w_grant   = w_req & m_gnt_i;
    w_s_grant = w_grant & ~w_sel_v;
    w_v_grant = w_grant &  w_sel_v;

    m_req_o   = w_req;
    m_id_o    = w_req & w_sel_v;
    m_we_o    = 1'b0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_be_o    = '0;
    if (w_req) begin
      m_we_o    = w_sel_v ? v_we_i    : s_we_i;
      m_addr_o  = w_sel_v ? v_addr_i  : s_addr_i;
      m_wdata_o = w_sel_v ? v_wdata_i : s_wdata_i;
      m_be_o    = w_sel_v ? v_be_i    : s_be_i;
    end
    s_gnt_o = w_s_grant;
    v_gnt_o = w_v_grant;
  end

  assign s_rvalid_o    = rst_ni & m_rvalid_i & ~m_rid_i;
  assign v_rvalid_o    = rst_ni & m_rvalid_i &  m_rid_i;
  assign rdata_o       = rst_ni ? m_rdata_i : '0;
  assign vst_pending_o = w_vst_busy;

  assign w_out_dec = m_rvalid_i & (r_out_cnt != '0);
  assign w_vst_inc = w_v_grant & v_we_i;
  assign w_vst_dec = m_rvalid_i & m_rid_i & m_rwe_i & w_vst_busy;

  // Outstanding-transaction counter: grant adds, any response retires one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_cnt <= '0;
    end else if (w_grant && !w_out_dec) begin
      r_out_cnt <= r_out_cnt + c_CNT_ONE;
    end else if (!w_grant && w_out_dec) begin
      r_out_cnt <= r_out_cnt - c_CNT_ONE;
    end
  end

  // Pending vector-store counter: vector write grant adds, vector write ack retires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vst_cnt <= '0;
    end else if (w_vst_inc && !w_vst_dec) begin
      r_vst_cnt <= r_vst_cnt + c_CNT_ONE;
    end else if (!w_vst_inc && w_vst_dec) begin
      r_vst_cnt <= r_vst_cnt - c_CNT_ONE;
    end
  end

  // Starvation counter: counts vector losses to scalar, saturates, clears when vector wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= '0;
    end else if (w_v_grant) begin
      r_starve_cnt <= '0;
    end else if (w_s_grant && w_v_elig && (r_starve_cnt != c_STV_MAX)) begin
      r_starve_cnt <= r_starve_cnt + c_STV_ONE;
    end
  end

  // A response with nothing outstanding indicates a broken dcache or requester.
  a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(m_rvalid_i && (r_out_cnt == '0)));

endmodule
`default_nettype wire

// File: tb/tb_vec_dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_dcache_port_arbiter
// Purpose  : Directed self-checking bench for vec_dcache_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_dcache_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          s_req_i, s_we_i;
  logic [AW-1:0] s_addr_i;
  logic [DW-1:0] s_wdata_i;
  logic [BW-1:0] s_be_i;
  logic          s_gnt_o;
  logic          v_req_i, v_we_i;
  logic [AW-1:0] v_addr_i;
  logic [DW-1:0] v_wdata_i;
  logic [BW-1:0] v_be_i;
  logic          v_gnt_o;
  logic          m_req_o, m_we_o, m_id_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic [BW-1:0] m_be_o;
  logic          m_gnt_i, m_rvalid_i, m_rid_i, m_rwe_i;
  logic [DW-1:0] m_rdata_i;
  logic          s_rvalid_o, v_rvalid_o, vst_pending_o;
  logic [DW-1:0] rdata_o;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_v;
  logic prev_v;

  vec_dcache_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(7), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_req_i(s_req_i), .s_we_i(s_we_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
    .s_be_i(s_be_i), .s_gnt_o(s_gnt_o),
    .v_req_i(v_req_i), .v_we_i(v_we_i), .v_addr_i(v_addr_i), .v_wdata_i(v_wdata_i),
    .v_be_i(v_be_i), .v_gnt_o(v_gnt_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_id_o(m_id_o), .m_gnt_i(m_gnt_i),
    .m_rvalid_i(m_rvalid_i), .m_rid_i(m_rid_i), .m_rwe_i(m_rwe_i), .m_rdata_i(m_rdata_i),
    .s_rvalid_o(s_rvalid_o), .v_rvalid_o(v_rvalid_o), .rdata_o(rdata_o),
    .vst_pending_o(vst_pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0;
    s_req_i = 1'b1; s_we_i = 1'b0; s_addr_i = 64'h1000; s_wdata_i = 64'h1111; s_be_i = 8'hff;
    v_req_i = 1'b0; v_we_i = 1'b0; v_addr_i = 64'h2000; v_wdata_i = 64'h2222; v_be_i = 8'h0f;
    m_gnt_i = 1'b1; m_rvalid_i = 1'b0; m_rid_i = 1'b0; m_rwe_i = 1'b0;
    m_rdata_i = 64'hDEAD_BEEF_0000_0001;

    // T1: reset gating, then request appears combinationally on release
    settle();
    chk("t1_rst_m_req", m_req_o, 1'b0);
    chk("t1_rst_s_gnt", s_gnt_o, 1'b0);
    chk("t1_rst_vst_pending", vst_pending_o, 1'b0);
    tick();
    rst_ni = 1'b1; m_gnt_i = 1'b0;
    settle();
    chk("t1_rel_m_req", m_req_o, 1'b1);
    chk("t1_rel_m_id", m_id_o, 1'b0);
    chk("t1_rel_m_addr", m_addr_o, 64'h1000);
    chk("t1_rel_s_gnt", s_gnt_o, 1'b0);
    tick();
    m_gnt_i = 1'b1;
    settle();
    chk("t1_s_gnt", s_gnt_o, 1'b1);
    tick();
    s_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = 1'b0;
    settle();
    chk("t1_s_rvalid", s_rvalid_o, 1'b1);
    chk("t1_v_rvalid", v_rvalid_o, 1'b0);
    chk("t1_rdata", rdata_o, 64'hDEAD_BEEF_0000_0001);
    tick();
    m_rvalid_i = 1'b0;

    // T2: scalar priority with forced vector win every fifth grant
    s_req_i = 1'b1; v_req_i = 1'b1; s_we_i = 1'b0; v_we_i = 1'b0; m_gnt_i = 1'b1;
    prev_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_v = (i == 4) || (i == 9);
      m_rvalid_i = (i != 0);
      m_rid_i = prev_v;
      settle();
      chk($sformatf("t2_v_gnt_%0d", i), v_gnt_o, exp_v);
      chk($sformatf("t2_s_gnt_%0d", i), s_gnt_o, !exp_v);
      chk($sformatf("t2_m_id_%0d", i), m_id_o, exp_v);
      prev_v = exp_v;
      tick();
    end
    s_req_i = 1'b0; v_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = 1'b1;
    settle();
    chk("t2_v_rvalid", v_rvalid_o, 1'b1);
    tick();
    m_rvalid_i = 1'b0;

    // T3: outstanding limit
    v_req_i = 1'b1; v_we_i = 1'b0; m_gnt_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk($sformatf("t3_v_gnt_%0d", i), v_gnt_o, 1'b1);
      tick();
    end
    m_rvalid_i = 1'b1; m_rid_i = 1'b1; m_rwe_i = 1'b0;
    settle();
    chk("t3_full_m_req", m_req_o, 1'b0);
    chk("t3_full_v_gnt", v_gnt_o, 1'b0);
    tick();
    m_rvalid_i = 1'b0;
    settle();
    chk("t3_freed_m_req", m_req_o, 1'b1);
    chk("t3_freed_v_gnt", v_gnt_o, 1'b1);
    tick();
    v_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk($sformatf("t3_drain_%0d", i), v_rvalid_o, 1'b1);
      tick();
    end
    m_rvalid_i = 1'b0;

    // T4: scalar load held behind vector store, scalar store not held
    v_req_i = 1'b1; v_we_i = 1'b1; v_addr_i = 64'h3000; m_gnt_i = 1'b1;
    settle();
    chk("t4_v_wr_gnt", v_gnt_o, 1'b1);
    chk("t4_m_we", m_we_o, 1'b1);
    chk("t4_m_wdata", m_wdata_o, 64'h2222);
    chk("t4_m_be", m_be_o, 8'h0f);
    tick();
    v_req_i = 1'b0; s_req_i = 1'b1; s_we_i = 1'b1; s_addr_i = 64'h4000;
    settle();
    chk("t4_vst_pending", vst_pending_o, 1'b1);
    chk("t4_s_wr_gnt", s_gnt_o, 1'b1);
    tick();
    s_we_i = 1'b0; s_addr_i = 64'h5000;
    settle();
    chk("t4_s_rd_held0", s_gnt_o, 1'b0);
    chk("t4_m_req_held0", m_req_o, 1'b0);
    tick();
    settle();
    chk("t4_s_rd_held1", s_gnt_o, 1'b0);
    tick();
    m_rvalid_i = 1'b1; m_rid_i = 1'b1; m_rwe_i = 1'b1;
    settle();
    chk("t4_s_rd_ack_cycle", s_gnt_o, 1'b0);
    tick();
    m_rvalid_i = 1'b0; m_rwe_i = 1'b0;
    settle();
    chk("t4_vst_clear", vst_pending_o, 1'b0);
    chk("t4_s_rd_gnt", s_gnt_o, 1'b1);
    chk("t4_m_addr", m_addr_o, 64'h5000);
    tick();
    s_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = 1'b0; m_rwe_i = 1'b1;
    tick();
    m_rwe_i = 1'b0;
    tick();
    m_rvalid_i = 1'b0;

    // T5: scalar lock holds mux while vector arrives
    s_req_i = 1'b1; s_we_i = 1'b0; s_addr_i = 64'h6000; m_gnt_i = 1'b0;
    settle();
    chk("t5_c0_m_id", m_id_o, 1'b0);
    chk("t5_c0_m_req", m_req_o, 1'b1);
    tick();
    v_req_i = 1'b1; v_we_i = 1'b0;
    settle();
    chk("t5_c1_m_id", m_id_o, 1'b0);
    chk("t5_c1_v_gnt", v_gnt_o, 1'b0);
    tick();
    settle();
    chk("t5_c2_m_id", m_id_o, 1'b0);
    tick();
    m_gnt_i = 1'b1;
    settle();
    chk("t5_c3_s_gnt", s_gnt_o, 1'b1);
    chk("t5_c3_m_id", m_id_o, 1'b0);
    tick();
    s_req_i = 1'b0;
    settle();
    chk("t5_c4_v_gnt", v_gnt_o, 1'b1);
    chk("t5_c4_m_id", m_id_o, 1'b1);
    tick();
    v_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = 1'b0;
    tick();
    m_rid_i = 1'b1;
    tick();
    m_rvalid_i = 1'b0;

    // T6: reset during LOCK_V with out_cnt=5 and vst_cnt=2
    v_req_i = 1'b1; v_we_i = 1'b1; m_gnt_i = 1'b1;
    tick();
    tick();
    v_we_i = 1'b0;
    tick();
    tick();
    tick();
    m_gnt_i = 1'b0;
    tick();
    s_req_i = 1'b1; s_we_i = 1'b1;
    settle();
    chk("t6_lockv_m_id", m_id_o, 1'b1);
    chk("t6_lockv_s_gnt", s_gnt_o, 1'b0);
    chk("t6_vst_pending", vst_pending_o, 1'b1);
    tick();
    rst_ni = 1'b0; v_req_i = 1'b0;
    settle();
    chk("t6_rst_m_req", m_req_o, 1'b0);
    chk("t6_rst_vst_pending", vst_pending_o, 1'b0);
    tick();
    rst_ni = 1'b1; s_we_i = 1'b0; s_addr_i = 64'h7000; m_gnt_i = 1'b1;
    settle();
    chk("t6_post_s_gnt", s_gnt_o, 1'b1);
    chk("t6_post_m_addr", m_addr_o, 64'h7000);
    chk("t6_post_vst_pending", vst_pending_o, 1'b0);
    tick();
    s_req_i = 1'b0; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rid_i = 1'b0;
    tick();
    m_rvalid_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
